// File: rtl/droute_switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : droute_switch_pkg
//  Description : Shared types and helpers for the segment-routing switch:
//                FSM state encoding, cfg word field offsets, clog2 and
//                destination-index helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package droute_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of the num_seg field in the cfg word
  localparam int c_num_seg_w = 8;
  // seg_len always sits at the bottom of the cfg word
  localparam int c_seg_len_lsb = 0;

  // Ceiling log2, never less than 1 so a select field always exists
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // cfg word = {rotate, first_dst[sel_w], num_seg[8], seg_len[cnt_w]}
  function automatic int cfg_num_seg_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int cfg_first_dst_lsb(input int cnt_w);
    return cnt_w + c_num_seg_w;
  endfunction

  function automatic int cfg_rotate_bit(input int cnt_w, input int sel_w);
    return cnt_w + c_num_seg_w + sel_w;
  endfunction

  // Out-of-range destination requests fall back to channel 0
  function automatic int dst_clamp(input int dst, input int num_out);
    return (dst >= num_out) ? 0 : dst;
  endfunction

  // Next destination, wrapping at num_out rather than at a power of two
  function automatic int dst_next(input int dst, input int num_out);
    return (dst + 1 >= num_out) ? 0 : dst + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/droute_skid.sv
`default_nettype none
// ============================================================================
//  Module      : droute_skid
//  Description : Two-entry skid buffer with a registered output slot. The
//                upstream ready depends only on local registers, so a stall
//                downstream reaches the input one cycle later at most.
//  Revision    : 1.0 - initial release
// ============================================================================
module droute_skid #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [PAYLOAD_W-1:0] i_s_data,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [PAYLOAD_W-1:0] o_m_data,
  output logic                 o_empty
);

  logic                 r_out_valid;
  logic [PAYLOAD_W-1:0] r_out_data;
  logic                 r_skid_valid;
  logic [PAYLOAD_W-1:0] r_skid_data;
  logic                 w_s_fire;

  assign o_s_ready = ~r_skid_valid;
  assign w_s_fire  = i_s_valid & ~r_skid_valid;
  assign o_m_valid = r_out_valid;
  assign o_m_data  = r_out_data;
  assign o_empty   = ~r_out_valid & ~r_skid_valid;

  // Refill the output slot from the skid entry first, else from the input;
  // park an incoming beat in the skid entry while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (!r_out_valid || i_m_ready) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_s_fire;
        if (w_s_fire) r_out_data <= i_s_data;
      end
    end else if (w_s_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_s_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/droute_switch.sv
`default_nettype none
// ============================================================================
//  Module      : droute_switch
//  Description : Routes num_seg segments of seg_len beats from one input
//                stream to NUM_OUT output channels, optionally rotating the
//                destination per segment. One-cycle latency through a skid
//                buffer feeding a combinational demux.
//  Revision    : 1.0 - initial release
// ============================================================================
module droute_switch
  import droute_switch_pkg::*;
#(
  parameter  int DATA_W  = 128,
  parameter  int NUM_OUT = 4,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = clog2(NUM_OUT),
  localparam int CFG_W   = CNT_W + 8 + SEL_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_W-1:0]          cfg_tdata,
  input  logic                      cfg_tvalid,
  output logic                      cfg_tready,
  input  logic [DATA_W-1:0]         s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [NUM_OUT*DATA_W-1:0] m_tdata,
  output logic [NUM_OUT-1:0]        m_tvalid,
  output logic [NUM_OUT-1:0]        m_tlast,
  input  logic [NUM_OUT-1:0]        m_tready,
  output logic                      busy,
  output logic                      done
);

  localparam int c_num_seg_lsb   = cfg_num_seg_lsb(CNT_W);
  localparam int c_first_dst_lsb = cfg_first_dst_lsb(CNT_W);
  localparam int c_rotate_bit    = cfg_rotate_bit(CNT_W, SEL_W);
  localparam int c_payload_w     = SEL_W + 1 + DATA_W;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_seg_last;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [c_num_seg_w-1:0]  r_num_last;
  logic [c_num_seg_w-1:0]  r_seg_cnt;
  logic                    r_rotate;
  logic [SEL_W-1:0]        r_dst;

  logic [CNT_W-1:0]        w_cfg_seg_len;
  logic [c_num_seg_w-1:0]  w_cfg_num_seg;
  logic [SEL_W-1:0]        w_cfg_first;
  logic                    w_cfg_rotate;
  logic                    w_cfg_empty;
  logic                    w_in_fire;
  logic                    w_beat_last;

  logic                    w_sk_in_ready;
  logic                    w_sk_out_valid;
  logic                    w_sk_out_ready;
  logic                    w_sk_empty;
  logic [c_payload_w-1:0]  w_sk_out_payload;
  logic [SEL_W-1:0]        w_sk_out_dst;
  logic                    w_sk_out_last;
  logic [DATA_W-1:0]       w_sk_out_data;

  assign w_cfg_seg_len = cfg_tdata[c_seg_len_lsb +: CNT_W];
  assign w_cfg_num_seg = cfg_tdata[c_num_seg_lsb +: c_num_seg_w];
  assign w_cfg_first   = cfg_tdata[c_first_dst_lsb +: SEL_W];
  assign w_cfg_rotate  = cfg_tdata[c_rotate_bit];
  assign w_cfg_empty   = (w_cfg_seg_len == '0) || (w_cfg_num_seg == '0);

  assign cfg_tready  = (r_state == ST_IDLE);
  assign s_tready    = (r_state == ST_RUN) && w_sk_in_ready;
  assign w_in_fire   = s_tvalid && s_tready;
  assign w_beat_last = (r_beat_cnt == r_seg_last);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DRAIN) && w_sk_empty;

  // Transaction sequencer: latch cfg, count beats/segments, step destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_seg_last <= '0;
      r_beat_cnt <= '0;
      r_num_last <= '0;
      r_seg_cnt  <= '0;
      r_rotate   <= 1'b0;
      r_dst      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_tvalid) begin
            r_seg_last <= w_cfg_seg_len - CNT_W'(1);
            r_num_last <= w_cfg_num_seg - c_num_seg_w'(1);
            r_rotate   <= w_cfg_rotate;
            r_dst      <= SEL_W'(dst_clamp(int'(w_cfg_first), NUM_OUT));
            r_beat_cnt <= '0;
            r_seg_cnt  <= '0;
            r_state    <= w_cfg_empty ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_in_fire) begin
            if (w_beat_last) begin
              r_beat_cnt <= '0;
              if (r_seg_cnt == r_num_last) begin
                r_state <= ST_DRAIN;
              end else begin
                r_seg_cnt <= r_seg_cnt + c_num_seg_w'(1);
                if (r_rotate) r_dst <= SEL_W'(dst_next(int'(r_dst), NUM_OUT));
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_sk_empty) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  droute_skid #(
    .PAYLOAD_W (c_payload_w)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_s_valid (s_tvalid && (r_state == ST_RUN)),
    .o_s_ready (w_sk_in_ready),
    .i_s_data  ({r_dst, w_beat_last, s_tdata}),
    .o_m_valid (w_sk_out_valid),
    .i_m_ready (w_sk_out_ready),
    .o_m_data  (w_sk_out_payload),
    .o_empty   (w_sk_empty)
  );

  assign {w_sk_out_dst, w_sk_out_last, w_sk_out_data} = w_sk_out_payload;
  assign w_sk_out_ready = m_tready[w_sk_out_dst];

  // Demux: only the addressed channel sees valid/last/data, others stay zero
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    logic w_sel;
    assign w_sel                      = w_sk_out_valid && (w_sk_out_dst == SEL_W'(k));
    assign m_tvalid[k]                = w_sel;
    assign m_tlast[k]                 = w_sel && w_sk_out_last;
    assign m_tdata[k*DATA_W +: DATA_W] = w_sel ? w_sk_out_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_droute_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_droute_switch
//  Description : Self-checking bench for droute_switch with a transaction-
//                level reference model and randomized data / ready stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_droute_switch;

  localparam int DATA_W  = 128;
  localparam int NUM_OUT = 4;
  localparam int CNT_W   = 16;
  localparam int SEL_W   = 2;
  localparam int CFG_W   = CNT_W + 8 + SEL_W + 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [CFG_W-1:0]          cfg_tdata = '0;
  logic                      cfg_tvalid = 1'b0;
  logic                      cfg_tready;
  logic [DATA_W-1:0]         s_tdata = '0;
  logic                      s_tvalid = 1'b0;
  logic                      s_tready;
  logic [NUM_OUT*DATA_W-1:0] m_tdata;
  logic [NUM_OUT-1:0]        m_tvalid;
  logic [NUM_OUT-1:0]        m_tlast;
  logic [NUM_OUT-1:0]        m_tready = '1;
  logic                      busy;
  logic                      done;

  droute_switch #(
    .DATA_W  (DATA_W),
    .NUM_OUT (NUM_OUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // ---------------- reference model (updated only by the compare process)
  bit                m_active = 0;
  bit                m_done_due = 0;
  bit                m_rot;
  int                m_first, m_slen, m_nseg, m_total, m_in_cnt, m_out_idx;
  logic [DATA_W-1:0] in_q[$];
  int                lg_ch[$];
  bit                lg_last[$];
  logic [DATA_W-1:0] lg_data[$];
  int                lg_cyc[$];
  int                cyc = 0, acc_cyc = 0, done_cyc = 0, last_fire_cyc = 0;
  int                busy_cyc = 0, sready_cyc = 0, done_cnt = 0;
  bit                rand_rdy = 0;

  always @(negedge clk) begin : cmp
    int  nv, vch, exp_ch, fd;
    bit  idle_bad, exp_last, was_active;
    cyc++;
    if (rst) begin
      m_active   = 0;
      m_done_due = 0;
      in_q.delete();
    end else begin
      nv = 0; vch = -1; idle_bad = 0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (m_tvalid[k]) begin nv++; vch = k; end
        else if (m_tlast[k] || (m_tdata[k*DATA_W +: DATA_W] != '0)) idle_bad = 1;
      end
      chk("one_valid_max", 128'(nv <= 1), 128'(1));
      chk("idle_ch_zero", 128'(idle_bad), 128'(0));
      chk("busy", 128'(busy), 128'(m_active));
      chk("done", 128'(done), 128'(m_done_due));
      chk("cfg_tready", 128'(cfg_tready), 128'(!m_active));
      chk("s_tready_gate", 128'(s_tready && !(m_active && m_in_cnt < m_total)), 128'(0));
      if (busy) busy_cyc++;
      if (s_tready) sready_cyc++;
      if (done) begin done_cyc = cyc; done_cnt++; end

      was_active = m_active;
      if (m_done_due) begin m_active = 0; m_done_due = 0; end

      if (vch >= 0) begin
        if (m_out_idx >= in_q.size()) chk("spurious_beat", 128'(vch), 128'(-1));
        else begin
          exp_ch   = m_rot ? (m_first + m_out_idx / m_slen) % NUM_OUT : m_first;
          exp_last = ((m_out_idx % m_slen) == m_slen - 1);
          chk("out_ch", 128'(vch), 128'(exp_ch));
          chk("out_data", m_tdata[vch*DATA_W +: DATA_W], in_q[m_out_idx]);
          chk("out_last", 128'(m_tlast[vch]), 128'(exp_last));
          if (m_tready[vch]) begin
            lg_ch.push_back(vch);
            lg_last.push_back(m_tlast[vch]);
            lg_data.push_back(m_tdata[vch*DATA_W +: DATA_W]);
            lg_cyc.push_back(cyc);
            last_fire_cyc = cyc;
            m_out_idx++;
            if (m_out_idx == m_total) m_done_due = 1;
          end
        end
      end

      if (!was_active && cfg_tvalid) begin
        m_slen  = int'(cfg_tdata[CNT_W-1:0]);
        m_nseg  = int'(cfg_tdata[CNT_W +: 8]);
        fd      = int'(cfg_tdata[CNT_W+8 +: SEL_W]);
        m_first = (fd >= NUM_OUT) ? 0 : fd;
        m_rot   = cfg_tdata[CFG_W-1];
        m_total = m_slen * m_nseg;
        m_in_cnt = 0; m_out_idx = 0;
        in_q.delete(); lg_ch.delete(); lg_last.delete(); lg_data.delete(); lg_cyc.delete();
        acc_cyc = cyc; busy_cyc = 0; sready_cyc = 0;
        m_active = 1;
        if (m_total == 0) m_done_due = 1;
      end

      if (s_tvalid && s_tready) begin
        in_q.push_back(s_tdata);
        m_in_cnt++;
      end
    end
  end

  // ---------------- stimulus
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = rand_rdy ? NUM_OUT'($urandom) : '1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_cfg(input bit rot, input int first, input int nseg, input int slen);
    int g = 0;
    cfg_tdata  = {rot, SEL_W'(first), 8'(nseg), CNT_W'(slen)};
    cfg_tvalid = 1'b1;
    while (g < 50) begin
      @(negedge clk);
      if (cfg_tready) break;
      g++;
    end
    tick();
    cfg_tvalid = 1'b0;
    if (g >= 50) chk("cfg_timeout", 128'(0), 128'(1));
  endtask

  task automatic stream(input int n, input bit incr);
    int sent = 0;
    int g = 0;
    s_tvalid = 1'b1;
    s_tdata  = incr ? DATA_W'(0) : rnd();
    while (sent < n && g < 20000) begin
      @(negedge clk);
      if (s_tready) begin
        sent++;
        tick();
        s_tdata = incr ? DATA_W'(sent) : rnd();
      end else begin
        tick();
      end
      g++;
    end
    s_tvalid = 1'b0;
    if (sent < n) chk("stream_timeout", 128'(sent), 128'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    while (g < 5000) begin
      @(negedge clk);
      if (!busy) break;
      g++;
    end
    tick();
    if (g >= 5000) chk("done_timeout", 128'(busy), 128'(0));
  endtask

  initial begin : main
    int exp_ch1[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    int done_before;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_tlast", 128'(m_tlast), 128'(0));
    chk("rst_m_tdata", 128'(|m_tdata), 128'(0));
    chk("rst_s_tready", 128'(s_tready), 128'(0));
    chk("rst_busy_done", 128'({busy, done}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("cfg_tready_after_rst", 128'(cfg_tready), 128'(1));
    tick();

    // three rotating segments of four incrementing beats starting on ch1
    send_cfg(1'b1, 1, 3, 4);
    stream(12, 1'b1);
    wait_done();
    chk("t1_count", 128'(lg_ch.size()), 128'(12));
    for (int i = 0; i < 12 && i < lg_ch.size(); i++) begin
      chk("t1_ch", 128'(lg_ch[i]), 128'(exp_ch1[i]));
      chk("t1_data", lg_data[i], 128'(i));
      chk("t1_last", 128'(lg_last[i]), 128'((i % 4) == 3));
    end
    if (lg_cyc.size() == 12) chk("t1_no_bubble", 128'(lg_cyc[11] - lg_cyc[0]), 128'(11));
    chk("t1_done_timing", 128'(done_cyc), 128'(last_fire_cyc + 1));

    // destination wrap from ch3 to ch0
    send_cfg(1'b1, 3, 2, 1);
    stream(2, 1'b0);
    wait_done();
    chk("t2_count", 128'(lg_ch.size()), 128'(2));
    if (lg_ch.size() == 2) begin
      chk("t2_ch0", 128'(lg_ch[0]), 128'(3));
      chk("t2_ch1", 128'(lg_ch[1]), 128'(0));
    end

    // zero-length transactions
    send_cfg(1'b0, 0, 5, 0);
    wait_done();
    chk("t3_busy_cycles", 128'(busy_cyc), 128'(1));
    chk("t3_no_s_tready", 128'(sready_cyc), 128'(0));
    chk("t3_done_timing", 128'(done_cyc), 128'(acc_cyc + 1));
    send_cfg(1'b1, 2, 0, 7);
    wait_done();
    chk("t3b_busy_cycles", 128'(busy_cyc), 128'(1));
    chk("t3b_done_timing", 128'(done_cyc), 128'(acc_cyc + 1));

    // long random transfer with random back-pressure
    rand_rdy = 1;
    send_cfg(1'b1, 2, 12, 64);
    stream(768, 1'b0);
    wait_done();
    rand_rdy = 0;
    chk("t4_count", 128'(lg_ch.size()), 128'(768));

    // cfg pulses during RUN are ignored
    send_cfg(1'b0, 2, 2, 3);
    stream(2, 1'b0);
    cfg_tdata  = {1'b1, SEL_W'(0), 8'(1), CNT_W'(1)};
    cfg_tvalid = 1'b1;
    tick(); tick();
    cfg_tvalid = 1'b0;
    stream(4, 1'b0);
    wait_done();
    chk("t5_count", 128'(lg_ch.size()), 128'(6));
    if (lg_ch.size() == 6) chk("t5_ch", 128'(lg_ch[5]), 128'(2));

    // reset in the middle of a transaction
    done_before = done_cnt;
    send_cfg(1'b1, 0, 2, 5);
    stream(5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("t6_m_tlast_data", 128'({m_tlast, |m_tdata}), 128'(0));
    chk("t6_s_tready", 128'(s_tready), 128'(0));
    chk("t6_busy_done", 128'({busy, done}), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_cfg_tready", 128'(cfg_tready), 128'(1));
    repeat (4) @(negedge clk);
    chk("t6_no_done", 128'(done_cnt), 128'(done_before));
    tick();

    // recovery after reset
    send_cfg(1'b0, 1, 1, 3);
    stream(3, 1'b0);
    wait_done();
    chk("t7_count", 128'(lg_ch.size()), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/droute_switch.md
DROUTE_SWITCH -- requirements
Module: droute_switch

Interface
REQ-001 Parameter DATA_W, default 128, payload width in bits; legal values are 8..1536.
REQ-002 Parameter NUM_OUT, default 4, number of output channels; legal values are 2..16.
REQ-003 Parameter CNT_W, default 16, width of the segment-length field.
REQ-004 Derived constants: SEL_W = clog2(NUM_OUT); CFG_W = CNT_W+8+SEL_W+1.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, on the ports below.
REQ-006 clk  in  1  sole clock; all logic is rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 cfg_tdata  in  CFG_W  {rotate, first_dst[SEL_W], num_seg[8], seg_len[CNT_W]}, MSB first.
REQ-009 cfg_tvalid / cfg_tready  in / out  1  configuration handshake.
REQ-010 s_tdata / s_tvalid / s_tready  in / in / out  DATA_W / 1 / 1  input stream.
REQ-011 m_tdata  out  NUM_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 m_tvalid / m_tlast / m_tready  out / out / in  NUM_OUT each  per-channel handshake; tlast marks the last beat of a segment.
REQ-013 busy  out  1  high from cfg acceptance until done.
REQ-014 done  out  1  single-cycle pulse at completion of a transaction.

Function
REQ-015 A transaction SHALL consist of num_seg segments of seg_len beats each.
- The first segment goes to channel first_dst.
- If rotate=1, each later segment goes to (previous dst + 1) mod NUM_OUT; if rotate=0, all segments go to first_dst.
REQ-016 first_dst >= NUM_OUT SHALL be treated as 0.
REQ-017 FSM states IDLE, RUN, DRAIN.
- IDLE -> RUN on cfg handshake.
- RUN -> DRAIN when the final input beat of the transaction is accepted.
- DRAIN -> IDLE when the output stage is empty; done pulses in that same cycle.
REQ-018 cfg_tready SHALL be 1 only in IDLE; s_tready SHALL be 1 only in RUN while the output stage can accept a beat.
REQ-019 seg_len=0 or num_seg=0: the transaction is accepted and goes directly to DRAIN; done pulses one cycle after acceptance; no input beat is consumed.
REQ-020 Latency SHALL be 1 cycle: a beat accepted at edge N is presented on m_* after edge N.
REQ-021 Throughput SHALL be 1 beat/cycle with its destination m_tready held high; no bubble at segment boundaries or on a channel switch.
REQ-022 Only the addressed channel's m_tvalid SHALL be asserted; the other channels drive tvalid=0, tlast=0, tdata=0.
REQ-023 m_tvalid SHALL stay high with stable data/last until m_tready; deasserting the destination's m_tready SHALL stall the input within 2 cycles with no loss or duplication.
REQ-024 Beat and segment counters SHALL count up and compare to seg_len-1 and num_seg-1; the destination index wraps mod NUM_OUT (not mod 2^SEL_W).
REQ-025 cfg_tvalid outside IDLE SHALL be ignored.
REQ-026 Simultaneous accept of the last input beat and output of the previous beat SHALL be handled without loss.

Reset
REQ-027 On rst, the block SHALL enter IDLE and clear all counters and the output stage.
REQ-028 Reset values: all m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, cfg_tready=1 (after reset release), busy=0, done=0.
REQ-029 rst mid-transaction SHALL discard in-flight beats; done SHALL NOT pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the cfg field offsets, and a clog2 function.
REQ-031 A sub-module droute_skid SHALL provide a 2-entry skid buffer carrying {dst, last, data}.
- It sits between the input and a combinational demux.
- One instance per block.

Verification
REQ-032 cfg {rotate=1, first_dst=1, num_seg=3, seg_len=4}, all m_tready=1, 12 incrementing beats -> ch1 gets beats 0-3, ch2 gets 4-7, ch3 gets 8-11; tlast on beats 3, 7, 11; done 1 cycle after the last output beat.
REQ-033 NUM_OUT=4, rotate=1, first_dst=3, num_seg=2, seg_len=1 -> beat 0 on ch3, beat 1 on ch0 (wrap).
REQ-034 seg_len=0 -> no s_tready assertion; done one cycle after the cfg handshake; busy high for exactly 1 cycle.
REQ-035 Random m_tready on the destination (50% duty), 768 beats of 128 bits, seg_len=64, num_seg=12 -> output sequence identical to input; no beat on an unaddressed channel.
REQ-036 rst asserted after 5 of 10 beats -> all outputs at reset values immediately; cfg_tready=1 the cycle after release; no done pulse.
REQ-037 cfg_tvalid pulsed during RUN -> ignored; the transaction completes per the original cfg.
